// File: rtl/onehot_pkg.sv
// Shared one-hot helpers: mux mode constants and a multi-hot detector.
// Used by the one-hot selector core and other one-hot blocks.
package onehot_pkg;

    localparam int MODE_OR   = 0;
    localparam int MODE_PRIO = 1;

    // Clearing the lowest set bit leaves a nonzero value only when two or more bits are set.
    function automatic logic popcount_gt1(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/onehot_mux_pipe_if.sv
// Producer/consumer bundle for the one-hot selector pipe stage.
// The slave modport is the stage's view; master is the surrounding system's view.
interface onehot_mux_pipe_if #(
    parameter int N_CH  = 4,
    parameter int W     = 32,
    parameter int CNT_W = 8
);

    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      out_data;
    logic              out_sel_err;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  err_count;
    logic              err_clear;

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_sel_err,
        output out_valid,
        input  out_ready,
        output err_count,
        input  err_clear
    );

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_sel_err,
        input  out_valid,
        output out_ready,
        input  err_count,
        output err_clear
    );

endinterface

// File: rtl/onehot_sel_core.sv
// Combinational one-hot selector: OR-combine or lowest-index-wins,
// plus a flag for zero-hot or multi-hot selects.
module onehot_sel_core
    import onehot_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 32,
    parameter int MODE = MODE_OR
) (
    input  logic [N_CH*W-1:0] ch_data,
    input  logic [N_CH-1:0]   sel,
    output logic [W-1:0]      sel_data,
    output logic              illegal
);

    always_comb begin
        sel_data = '0;
        if (MODE == MODE_PRIO) begin
            // Walk downward so the lowest set index is written last.
            for (int k = N_CH - 1; k >= 0; k--) begin
                if (sel[k]) sel_data = ch_data[k*W +: W];
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (sel[k]) sel_data = sel_data | ch_data[k*W +: W];
            end
        end
    end

    assign illegal = (sel == '0) || popcount_gt1(32'(sel));

endmodule

// File: rtl/onehot_mux_pipe.sv
// Registered one-hot data selector with valid/ready on both sides
// and a saturating counter of accepted illegal selects.
module onehot_mux_pipe
    import onehot_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 32,
    parameter int MODE  = MODE_OR,
    parameter int CNT_W = 8
) (
    input logic              clock,
    input logic              reset,
    onehot_mux_pipe_if.slave bus
);

    logic [W-1:0]     sel_data;
    logic             illegal;
    logic             accept;
    logic [W-1:0]     data_q;
    logic             err_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    onehot_sel_core #(
        .N_CH (N_CH),
        .W    (W),
        .MODE (MODE)
    ) u_core (
        .ch_data  (bus.in_data),
        .sel      (bus.in_sel),
        .sel_data (sel_data),
        .illegal  (illegal)
    );

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= sel_data;
            err_q   <= illegal;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Clear beats a same-cycle increment; the all-ones value sticks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (bus.err_clear) begin
            cnt_q <= '0;
        end else if (accept && illegal && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.out_data    = data_q;
    assign bus.out_sel_err = err_q;
    assign bus.out_valid   = valid_q;
    assign bus.err_count   = cnt_q;

endmodule

// File: tb/tb_onehot_mux_pipe.sv
// Directed bench for onehot_mux_pipe: OR/PRIO mode instances plus a
// 2-bit counter instance, all driven with the same stimulus.
module tb_onehot_mux_pipe;

    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;

    logic [31:0] got[$];
    logic [31:0] exp_q[$];

    onehot_mux_pipe_if #(.N_CH(4), .W(32), .CNT_W(8)) bo();
    onehot_mux_pipe_if #(.N_CH(4), .W(32), .CNT_W(8)) bp();
    onehot_mux_pipe_if #(.N_CH(4), .W(32), .CNT_W(2)) bs();

    onehot_mux_pipe #(.N_CH(4), .W(32), .MODE(0), .CNT_W(8)) u_or (
        .clock (clock),
        .reset (reset),
        .bus   (bo)
    );

    onehot_mux_pipe #(.N_CH(4), .W(32), .MODE(1), .CNT_W(8)) u_pr (
        .clock (clock),
        .reset (reset),
        .bus   (bp)
    );

    onehot_mux_pipe #(.N_CH(4), .W(32), .MODE(0), .CNT_W(2)) u_sat (
        .clock (clock),
        .reset (reset),
        .bus   (bs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bo.out_valid && bo.out_ready) got.push_back(bo.out_data);
    end

    function automatic logic [127:0] pack(
        input logic [31:0] c0, input logic [31:0] c1,
        input logic [31:0] c2, input logic [31:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic drive(input logic [127:0] d, input logic [3:0] s, input logic v);
        bo.in_data = d; bo.in_sel = s; bo.in_valid = v;
        bp.in_data = d; bp.in_sel = s; bp.in_valid = v;
        bs.in_data = d; bs.in_sel = s; bs.in_valid = v;
    endtask

    task automatic set_ready(input logic r);
        bo.out_ready = r; bp.out_ready = r; bs.out_ready = r;
    endtask

    task automatic set_clear(input logic c);
        bo.err_clear = c; bp.err_clear = c; bs.err_clear = c;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] c [4];
        int k;

        reset = 1'b0;
        drive('0, '0, 1'b0);
        set_ready(1'b1);
        set_clear(1'b0);
        #3;
        chk("rst_out_valid", 32'(bo.out_valid), 32'd0);
        chk("rst_out_data", bo.out_data, 32'd0);
        chk("rst_sel_err", 32'(bo.out_sel_err), 32'd0);
        chk("rst_err_count", 32'(bo.err_count), 32'd0);
        chk("rst_in_ready", 32'(bo.in_ready), 32'd1);
        tick();
        #2 reset = 1'b1;
        tick();

        // Legal one-hot select
        drive(pack(32'd11, 32'd22, 32'd33, 32'd44), 4'b0100, 1'b1);
        tick();
        drive('0, '0, 1'b0);
        chk("legal_valid", 32'(bo.out_valid), 32'd1);
        chk("legal_data_or", bo.out_data, 32'd33);
        chk("legal_data_pr", bp.out_data, 32'd33);
        chk("legal_sel_err", 32'(bo.out_sel_err), 32'd0);
        chk("legal_err_count", 32'(bo.err_count), 32'd0);

        // Multi-hot select
        drive(pack(32'h0, 32'h0F, 32'hF0, 32'h0), 4'b0110, 1'b1);
        tick();
        drive('0, '0, 1'b0);
        chk("multi_data_or", bo.out_data, 32'hFF);
        chk("multi_data_pr", bp.out_data, 32'h0F);
        chk("multi_err_or", 32'(bo.out_sel_err), 32'd1);
        chk("multi_err_pr", 32'(bp.out_sel_err), 32'd1);
        chk("multi_cnt_or", 32'(bo.err_count), 32'd1);
        chk("multi_cnt_pr", 32'(bp.err_count), 32'd1);
        tick();
        chk("drain_valid", 32'(bo.out_valid), 32'd0);
        chk("drain_hold", bo.out_data, 32'hFF);

        // Reset while a beat is held under backpressure
        set_ready(1'b0);
        drive(pack(32'h55, 32'h0, 32'h0, 32'h0), 4'b0001, 1'b1);
        tick();
        drive('0, '0, 1'b0);
        chk("held_valid", 32'(bo.out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(bo.out_valid), 32'd0);
        chk("midrst_cnt", 32'(bo.err_count), 32'd0);
        chk("midrst_data", bo.out_data, 32'd0);
        tick();
        #2 reset = 1'b1;
        set_ready(1'b1);
        tick();
        chk("post_rst_ready", 32'(bo.in_ready), 32'd1);
        chk("post_rst_no_replay", 32'(bo.out_valid), 32'd0);

        // Backpressure: A, B, C with two stalled cycles
        got.delete();
        drive(pack(32'hA1, 32'h0, 32'h0, 32'h0), 4'b0001, 1'b1);
        tick();
        set_ready(1'b0);
        drive(pack(32'h0, 32'hB2, 32'h0, 32'h0), 4'b0010, 1'b1);
        #1;
        chk("bp_in_ready0", 32'(bo.in_ready), 32'd0);
        chk("bp_data_a0", bo.out_data, 32'hA1);
        tick();
        chk("bp_data_a1", bo.out_data, 32'hA1);
        tick();
        chk("bp_data_a2", bo.out_data, 32'hA1);
        chk("bp_in_ready2", 32'(bo.in_ready), 32'd0);
        set_ready(1'b1);
        tick();
        chk("bp_data_b", bo.out_data, 32'hB2);
        drive(pack(32'h0, 32'h0, 32'h0, 32'hC3), 4'b1000, 1'b1);
        tick();
        chk("bp_data_c", bo.out_data, 32'hC3);
        drive('0, '0, 1'b0);
        tick();
        tick();
        chk("bp_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("bp_order0", got[0], 32'hA1);
            chk("bp_order1", got[1], 32'hB2);
            chk("bp_order2", got[2], 32'hC3);
        end

        // Saturation and clear priority
        for (int i = 0; i < 5; i++) begin
            drive(pack(32'h1, 32'h2, 32'h4, 32'h8), 4'b0000, 1'b1);
            tick();
        end
        drive('0, '0, 1'b0);
        chk("sat_cnt2", 32'(bs.err_count), 32'd3);
        chk("sat_cnt8", 32'(bo.err_count), 32'd5);
        chk("zero_hot_data", bo.out_data, 32'd0);
        chk("zero_hot_err", 32'(bo.out_sel_err), 32'd1);
        set_clear(1'b1);
        drive(pack(32'h1, 32'h2, 32'h4, 32'h8), 4'b1111, 1'b1);
        tick();
        set_clear(1'b0);
        drive('0, '0, 1'b0);
        chk("clr_cnt2", 32'(bs.err_count), 32'd0);
        chk("clr_cnt8", 32'(bo.err_count), 32'd0);
        chk("clr_beat_data", bo.out_data, 32'hF);
        chk("clr_beat_err", 32'(bo.out_sel_err), 32'd1);
        tick();

        // Throughput: 100 legal beats back to back
        got.delete();
        exp_q.delete();
        set_ready(1'b1);
        for (int i = 0; i < 100; i++) begin
            for (int j = 0; j < 4; j++) c[j] = $urandom;
            k = $urandom_range(0, 3);
            exp_q.push_back(c[k]);
            drive(pack(c[0], c[1], c[2], c[3]), 4'(1 << k), 1'b1);
            tick();
        end
        drive('0, '0, 1'b0);
        tick();
        chk("tput_count", 32'(got.size()), 32'd100);
        chk("tput_cnt_err", 32'(bo.err_count), 32'd0);
        if (got.size() == 100) begin
            for (int i = 0; i < 100; i++) chk($sformatf("tput_beat%0d", i), got[i], exp_q[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
